sn76489_cmdqueue_wb8: RTL and testbench

//  Timed command queue feeding the sn76489_wb8 PSG. CPU pushes PSG register bytes and wait tokens

---
 rtl/sn76489_cmdqueue_wb8_if.sv | 28 ++
 rtl/sn76489_cmdqueue_wb8.sv | 164 ++++++++++++++++
 tb/tb_sn76489_cmdqueue_wb8.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sn76489_cmdqueue_wb8_if.sv
// 8-bit Wishbone-style bus. The CPU-side port and the PSG-side port of the command queue
// both use this interface.
interface sn76489_cmdqueue_wb8_if;
  logic [1:0] adr;
  logic [7:0] dat_w;
  logic [7:0] dat_r;
  logic       stb;
  logic       we;
  logic       ack;

  modport master (
    output adr,
    output dat_w,
    output stb,
    output we,
    input  ack,
    input  dat_r
  );

  modport slave (
    input  adr,
    input  dat_w,
    input  stb,
    input  we,
    output ack,
    output dat_r
  );
endinterface

// File: rtl/sn76489_cmdqueue_wb8.sv
// Timed command queue for the sn76489_wb8 PSG. The CPU pushes PSG bytes and wait tokens, and a
// sequencer replays them to the PSG with tick-accurate spacing.
module sn76489_cmdqueue_wb8 #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned TICKDIVIDE = 1134
) (
  input  logic                          I_wb_clk,
  input  logic                          I_reset,
  sn76489_cmdqueue_wb8_if.slave         cpu_bus,
  sn76489_cmdqueue_wb8_if.master        psg_bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = (TICKDIVIDE > 1) ? $clog2(TICKDIVIDE) : 1;
  localparam logic [TW-1:0] TickReload = TW'(TICKDIVIDE - 1);
  localparam logic [LW-1:0] LevelFull  = LW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StAckWait, StWait} state_e;

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          ovf_q, pause_q, ack_q;
  logic [7:0]    dat_r_q, rd_mux;
  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    wait_q, wait_d;
  logic [7:0]    psg_dat_q, psg_dat_d;

  logic accept, wr_acc, push_req, ctrl_wr, flush;
  logic empty, full, idle, pop, push, drop;
  logic [8:0] head;

  assign accept   = cpu_bus.stb & ~ack_q;
  assign wr_acc   = accept & cpu_bus.we;
  assign push_req = wr_acc & ~cpu_bus.adr[1];
  assign ctrl_wr  = wr_acc & (cpu_bus.adr == 2'd2);
  assign flush    = ctrl_wr & cpu_bus.dat_w[0];

  assign empty = (level_q == '0);
  assign full  = (level_q == LevelFull);
  assign idle  = (state_q == StIdle) & empty;
  assign head  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands then.
  assign pop  = (state_q == StIdle) & ~empty & ~pause_q & ~flush;
  assign push = push_req & (~full | pop);
  assign drop = push_req & full & ~pop;

  always_ff @(posedge I_wb_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cpu_bus.adr[0], cpu_bus.dat_w};
    end
  end

  always_ff @(posedge I_wb_clk) begin
    if (I_reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    unique case (cpu_bus.adr)
      2'd0:    rd_mux = 8'(level_q);
      2'd1:    rd_mux = {3'b000, pause_q, ovf_q, idle, full, empty};
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      ack_q   <= 1'b0;
      pause_q <= 1'b0;
      dat_r_q <= 8'h00;
    end else begin
      ack_q <= accept;
      if (ctrl_wr) pause_q <= cpu_bus.dat_w[1];
      if (accept)  dat_r_q <= cpu_bus.we ? 8'h00 : rd_mux;
    end
  end

  assign cpu_bus.ack   = ack_q;
  assign cpu_bus.dat_r = dat_r_q;

  // Sequencer. Pause only gates new pops and freezes the wait counters.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    wait_d    = wait_q;
    psg_dat_d = psg_dat_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          if (head[8]) begin
            state_d = StWait;
            wait_d  = head[7:0];
            tick_d  = TickReload;
          end else begin
            state_d   = StIssue;
            psg_dat_d = head[7:0];
          end
        end
      end
      StIssue: state_d = StAckWait;
      StAckWait: begin
        if (psg_bus.ack) state_d = StIdle;
      end
      StWait: begin
        if (flush) begin
          state_d = StIdle;
        end else if (!pause_q) begin
          if (tick_q == '0) begin
            tick_d = TickReload;
            if (wait_q == 8'h00) begin
              state_d = StIdle;
            end else begin
              wait_d = wait_q - 8'h01;
            end
          end else begin
            tick_d = tick_q - 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      state_q   <= StIdle;
      tick_q    <= '0;
      wait_q    <= 8'h00;
      psg_dat_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      wait_q    <= wait_d;
      psg_dat_q <= psg_dat_d;
    end
  end

  assign psg_bus.adr   = 2'd0;
  assign psg_bus.dat_w = psg_dat_q;
  assign psg_bus.stb   = (state_q == StIssue);
  assign psg_bus.we    = 1'b1;

  logic unused_psg;
  assign unused_psg = ^psg_bus.dat_r;

endmodule

// File: tb/tb_sn76489_cmdqueue_wb8.sv
// Bench for sn76489_cmdqueue_wb8: a one-cycle-ack PSG responder, a strobe monitor and a
// queue-based model of expected PSG bytes and strobe spacing.
module tb_sn76489_cmdqueue_wb8;

  localparam int unsigned Depth = 8;
  localparam int unsigned Tick  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sn76489_cmdqueue_wb8_if cpu_bus ();
  sn76489_cmdqueue_wb8_if psg_bus ();

  sn76489_cmdqueue_wb8 #(
    .DEPTH      (Depth),
    .TICKDIVIDE (Tick)
  ) u_dut (
    .I_wb_clk (clk),
    .I_reset  (rst),
    .cpu_bus  (cpu_bus),
    .psg_bus  (psg_bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;
  int unsigned obs_t[$];
  logic [7:0]  obs_d[$];

  always @(posedge clk) cyc <= cyc + 1;

  // PSG stand-in: registered single-cycle acknowledge.
  always @(posedge clk) begin
    if (rst) psg_bus.ack <= 1'b0;
    else     psg_bus.ack <= psg_bus.stb & ~psg_bus.ack;
  end
  assign psg_bus.dat_r = 8'h00;

  always @(negedge clk) begin
    if (psg_bus.stb === 1'b1) begin
      obs_t.push_back(cyc);
      obs_d.push_back(psg_bus.dat_w);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the slave ack already cleared.
  task automatic bus_xfer(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                          output logic [7:0] rdat, output int unsigned t);
    int unsigned n = 0;
    cpu_bus.stb   = 1'b1;
    cpu_bus.we    = we;
    cpu_bus.adr   = adr;
    cpu_bus.dat_w = dat;
    t = cyc;
    do begin
      @(negedge clk);
      n++;
    end while (cpu_bus.ack !== 1'b1 && n < 10);
    if (cpu_bus.ack !== 1'b1) check("bus_ack_timeout", 32'(cpu_bus.ack), 32'd1);
    rdat        = cpu_bus.dat_r;
    cpu_bus.stb = 1'b0;
    cpu_bus.we  = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] adr, input logic [7:0] dat);
    logic [7:0] r;
    int unsigned t;
    bus_xfer(1'b1, adr, dat, r, t);
  endtask

  task automatic wr_t(input logic [1:0] adr, input logic [7:0] dat, output int unsigned t);
    logic [7:0] r;
    bus_xfer(1'b1, adr, dat, r, t);
  endtask

  task automatic rd(input logic [1:0] adr, output logic [7:0] v);
    int unsigned t;
    bus_xfer(1'b0, adr, 8'h00, v, t);
  endtask

  task automatic wait_strobes(input int unsigned n, input int unsigned budget);
    int unsigned k = 0;
    while (obs_d.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (obs_d.size() < n) check("strobe_timeout", obs_d.size(), n);
  endtask

  logic [7:0]  v;
  logic [7:0]  ref_bytes[$];
  int unsigned ref_gaps[$];
  int unsigned p_t, u_t, pend, nb, n_items;
  bit          seen_byte;

  initial begin
    rst           = 1'b1;
    cpu_bus.stb   = 1'b0;
    cpu_bus.we    = 1'b0;
    cpu_bus.adr   = 2'd0;
    cpu_bus.dat_w = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_psg_stb", 32'(psg_bus.stb), 32'd0);
    check("rst_wb_ack", 32'(cpu_bus.ack), 32'd0);
    check("rst_wb_dat", 32'(cpu_bus.dat_r), 32'd0);
    check("rst_psg_dat", 32'(psg_bus.dat_w), 32'd0);
    check("psg_we", 32'(psg_bus.we), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rd(2'd0, v); check("rst_level", 32'(v), 32'd0);
    rd(2'd1, v); check("rst_status", 32'(v), 32'h05);
    rd(2'd3, v); check("rd_adr3", 32'(v), 32'd0);

    // Back-to-back bytes: 3 cycles apart.
    wr(2'd2, 8'h02);
    wr(2'd0, 8'h9F);
    wr(2'd0, 8'hBF);
    obs_d.delete(); obs_t.delete();
    wr(2'd2, 8'h00);
    wait_strobes(2, 50);
    if (obs_d.size() >= 2) begin
      check("b2b_dat0", 32'(obs_d[0]), 32'h9F);
      check("b2b_dat1", 32'(obs_d[1]), 32'hBF);
      check("b2b_gap", obs_t[1] - obs_t[0], 32'd3);
    end

    // Byte, wait 2, byte: IDLE pop cycle plus (2+1)*Tick cycles of WAIT.
    wr(2'd2, 8'h02);
    wr(2'd0, 8'h80);
    wr(2'd1, 8'h02);
    wr(2'd0, 8'h85);
    obs_d.delete(); obs_t.delete();
    wr(2'd2, 8'h00);
    wait_strobes(2, 100);
    if (obs_d.size() >= 2) begin
      check("wait2_dat1", 32'(obs_d[1]), 32'h85);
      check("wait2_gap", obs_t[1] - obs_t[0], 32'(3 + 1 + 3 * Tick));
    end
    repeat (20) @(negedge clk);
    check("wait2_no_extra", obs_d.size(), 32'd2);

    // Overflow while paused.
    wr(2'd2, 8'h02);
    ref_bytes.delete();
    for (int i = 0; i < Depth + 1; i++) begin
      v = 8'($urandom);
      if (i < Depth) ref_bytes.push_back(v);
      wr(2'd0, v);
    end
    rd(2'd0, v); check("ovf_level", 32'(v), Depth);
    rd(2'd1, v); check("ovf_status", 32'(v), 32'h1A);
    obs_d.delete(); obs_t.delete();
    wr(2'd2, 8'h00);
    wait_strobes(Depth, 200);
    for (int i = 0; i < Depth && i < obs_d.size(); i++) check("ovf_drain", 32'(obs_d[i]), 32'(ref_bytes[i]));
    repeat (10) @(negedge clk);
    check("ovf_drain_count", obs_d.size(), Depth);
    rd(2'd1, v); check("ovf_status_drained", 32'(v), 32'h0D);
    wr(2'd2, 8'h01);
    rd(2'd1, v); check("flush_clears_ovf", 32'(v), 32'h05);

    // Wait 255 with a pause in the middle; frozen cycles add one-for-one.
    wr(2'd2, 8'h02);
    wr(2'd0, 8'h11);
    wr(2'd1, 8'hFF);
    wr(2'd0, 8'h22);
    obs_d.delete(); obs_t.delete();
    wr(2'd2, 8'h00);
    wait_strobes(1, 50);
    repeat (100) @(negedge clk);
    wr_t(2'd2, 8'h02, p_t);
    repeat (7) @(negedge clk);
    wr_t(2'd2, 8'h00, u_t);
    wait_strobes(2, 2000);
    if (obs_d.size() >= 2) begin
      check("w255_dat1", 32'(obs_d[1]), 32'h22);
      check("w255_gap", obs_t[1] - obs_t[0], 3 + 1 + 256 * Tick + (u_t - p_t));
    end

    // Flush during a long wait with five entries behind it.
    wr(2'd2, 8'h02);
    wr(2'd1, 8'd50);
    for (int i = 0; i < 5; i++) wr(2'd0, 8'h40 + 8'(i));
    obs_d.delete(); obs_t.delete();
    wr(2'd2, 8'h00);
    repeat (20) @(negedge clk);
    rd(2'd0, v); check("flush_pre_level", 32'(v), 32'd5);
    wr(2'd2, 8'h01);
    rd(2'd0, v); check("flush_level", 32'(v), 32'd0);
    rd(2'd1, v); check("flush_status", 32'(v), 32'h05);
    repeat (300) @(negedge clk);
    check("flush_no_strobes", obs_d.size(), 32'd0);

    // Reset in the ISSUE cycle.
    wr(2'd2, 8'h02);
    wr(2'd0, 8'h33);
    wr(2'd2, 8'h00);
    for (int k = 0; k < 20 && psg_bus.stb !== 1'b1; k++) @(negedge clk);
    check("pre_reset_issue", 32'(psg_bus.stb), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("reset_kills_stb", 32'(psg_bus.stb), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rd(2'd0, v); check("post_rst_level", 32'(v), 32'd0);
    rd(2'd1, v); check("post_rst_status", 32'(v), 32'h05);
    obs_d.delete(); obs_t.delete();
    wr(2'd0, 8'h44);
    wait_strobes(1, 50);
    if (obs_d.size() >= 1) check("post_rst_push", 32'(obs_d[0]), 32'h44);

    // Random mixes of bytes and short waits, checked for order and spacing.
    for (int r = 0; r < 6; r++) begin
      wr(2'd2, 8'h02);
      ref_bytes.delete(); ref_gaps.delete();
      n_items   = $urandom_range(Depth, 1);
      pend      = 0;
      seen_byte = 1'b0;
      for (int i = 0; i < n_items; i++) begin
        if ($urandom_range(3, 0) == 0) begin
          v = 8'($urandom_range(3, 0));
          wr(2'd1, v);
          pend += 1 + (int'(v) + 1) * Tick;
        end else begin
          v = 8'($urandom);
          wr(2'd0, v);
          if (seen_byte) ref_gaps.push_back(3 + pend);
          ref_bytes.push_back(v);
          seen_byte = 1'b1;
          pend = 0;
        end
      end
      rd(2'd0, v); check("rnd_level", 32'(v), n_items);
      obs_d.delete(); obs_t.delete();
      wr(2'd2, 8'h00);
      nb = ref_bytes.size();
      wait_strobes(nb, 600);
      for (int i = 0; i < nb && i < obs_d.size(); i++) begin
        check("rnd_dat", 32'(obs_d[i]), 32'(ref_bytes[i]));
        if (i > 0) check("rnd_gap", obs_t[i] - obs_t[i-1], ref_gaps[i-1]);
      end
      repeat (6 * Tick) @(negedge clk);
      rd(2'd1, v); check("rnd_status_idle", 32'(v), 32'h05);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
